stack_arbiter: RTL and testbench

Two-port arbiter and sequencer that shares one 8-entry, 4-bit LIFO stack between two requesters. It accepts push and pop requests from both ports and grants them round-robin. It tracks stack occupancy itself, rejects illegal operations (push when full, pop when empty), issues single-cycle push/pop strobes to the stack and returns pop data to the winning port. It sits between the requester logic and the stack module; the stack's own full/empty flags are not used.

---
 rtl/stack_arb_pkg.sv | 20 ++
 rtl/stack_arbiter_rr_arb2.sv | 39 +++
 rtl/stack_arbiter.sv | 171 +++++++++++++++++
 tb/tb_stack_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_arb_pkg.sv
// stack_arb_pkg
//   Shared types and constants for the two-port stack arbiter slice.
//   - state_t      : sequencer states (IDLE, ISSUE, POP_WAIT)
//   - OP_PUSH/POP  : encoding of the per-port op input
//   - DEF_DATA_W / DEF_DEPTH : default stack geometry (4-bit x 8 entries)
package stack_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    POP_WAIT = 2'd2
  } state_t;

  localparam logic OP_PUSH = 1'b1;
  localparam logic OP_POP  = 1'b0;

  localparam int DEF_DATA_W = 4;
  localparam int DEF_DEPTH  = 8;

endpackage

// File: rtl/stack_arbiter_rr_arb2.sv
// rr_arb2
//   Two-requester round-robin picker with a last-winner pointer.
//   Ports:
//     clk, rstN  : clock, synchronous active-low reset
//     req[1:0]   : request vector (bit n = port n)
//     update     : advance the pointer to the current winner this cycle
//     gnt[1:0]   : one-hot winner (combinational), 0 when no request
//   After reset the pointer behaves as if port 1 won last, so port 0 wins
//   the first contention.
module rr_arb2
  import stack_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rstN,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] gnt
);

  logic last_win;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_win ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstN)
      last_win <= 1'b1;
    else if (update && (|req))
      last_win <= gnt[1];
  end

endmodule

// File: rtl/stack_arbiter.sv
// stack_arbiter
//   Shares one LIFO stack between two requesters. Grants push/pop requests
//   round-robin, tracks occupancy, rejects push-when-full / pop-when-empty,
//   drives registered single-cycle strobes to the stack and returns popped
//   data to the winning port.
//   Ports:
//     clk, rstN              : clock, synchronous active-low reset
//     req0/1, op0/1, wdata0/1: per-port request, op (1 push / 0 pop), push data
//     gnt0/1, err0/1         : grant pulse, reject pulse (with grant)
//     rvalid0/1, rdata       : pop result pulse per port, shared data (held)
//     stk_push, stk_pop      : strobes to the stack
//     stk_din, stk_dout      : push data to stack, read data from stack
//     count                  : current occupancy
//   Optional feature macro STACK_ARB_STATS_EN adds err_cnt / ops_cnt
//   (8-bit saturating counts of rejected grants and completed legal ops).
module stack_arbiter
  import stack_arb_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int DEPTH  = DEF_DEPTH,
  localparam int CW     = $clog2(DEPTH + 1)
)(
  input  logic              clk,
  input  logic              rstN,
  input  logic              req0,
  input  logic              req1,
  input  logic              op0,
  input  logic              op1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              err0,
  output logic              err1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              stk_push,
  output logic              stk_pop,
  output logic [DATA_W-1:0] stk_din,
  input  logic [DATA_W-1:0] stk_dout,
  output logic [CW-1:0]     count
`ifdef STACK_ARB_STATS_EN
  ,
  output logic [7:0]        err_cnt,
  output logic [7:0]        ops_cnt
`endif
);

  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW-1:0] ONE  = CW'(1);

  state_t            state, state_next;
  logic [1:0]        arb_gnt;
  logic              win;
  logic              win_op;
  logic [DATA_W-1:0] win_data;
  logic              legal;
  logic              fire;
  logic              port_q;
  logic              op_q;

  rr_arb2 u_arb (
    .clk    (clk),
    .rstN   (rstN),
    .req    ({req1, req0}),
    .update (fire),
    .gnt    (arb_gnt)
  );

  assign win      = arb_gnt[1];
  assign win_op   = win ? op1 : op0;
  assign win_data = win ? wdata1 : wdata0;
  assign legal    = (win_op == OP_PUSH) ? (count != FULL) : (count != '0);

  always_ff @(posedge clk) begin
    if (!rstN)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Requests are only looked at in IDLE; a rejected op stays in IDLE so the
  // next grant can happen one cycle later.
  always_comb begin
    state_next = state;
    fire       = 1'b0;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          fire = 1'b1;
          if (legal)
            state_next = ISSUE;
        end
      end
      ISSUE:    state_next = (op_q == OP_PUSH) ? IDLE : POP_WAIT;
      POP_WAIT: state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Pulse outputs default low every cycle; count moves at grant time so a
  // back-to-back request already sees the new occupancy.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      err0     <= 1'b0;
      err1     <= 1'b0;
      rvalid0  <= 1'b0;
      rvalid1  <= 1'b0;
      rdata    <= '0;
      stk_push <= 1'b0;
      stk_pop  <= 1'b0;
      stk_din  <= '0;
      count    <= '0;
      port_q   <= 1'b0;
      op_q     <= OP_POP;
    end else begin
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      err0     <= 1'b0;
      err1     <= 1'b0;
      rvalid0  <= 1'b0;
      rvalid1  <= 1'b0;
      stk_push <= 1'b0;
      stk_pop  <= 1'b0;
      if (fire) begin
        gnt0   <= ~win;
        gnt1   <= win;
        port_q <= win;
        op_q   <= win_op;
        if (legal) begin
          if (win_op == OP_PUSH) begin
            stk_push <= 1'b1;
            stk_din  <= win_data;
            count    <= count + ONE;
          end else begin
            stk_pop <= 1'b1;
            count   <= count - ONE;
          end
        end else begin
          err0 <= ~win;
          err1 <= win;
        end
      end
      if (state == POP_WAIT) begin
        rdata   <= stk_dout;
        rvalid0 <= ~port_q;
        rvalid1 <= port_q;
      end
    end
  end

`ifdef STACK_ARB_STATS_EN
  // A push completes when its strobe reaches the stack, a pop when its data
  // is returned; a pop aborted by reset is therefore never counted.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      err_cnt <= '0;
      ops_cnt <= '0;
    end else begin
      if (fire && !legal && (err_cnt != 8'hFF))
        err_cnt <= err_cnt + 8'd1;
      if (((state == ISSUE && op_q == OP_PUSH) || state == POP_WAIT) && (ops_cnt != 8'hFF))
        ops_cnt <= ops_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_stack_arbiter.sv
// tb_stack_arbiter
//   Self-checking bench for stack_arbiter with a small behavioural LIFO
//   attached to the stack strobes. Table-driven single-transaction vectors
//   plus hand-written sequences for back-to-back timing and reset mid-pop.
//   Stats checks are compiled in when STACK_ARB_STATS_EN is defined.
module tb_stack_arbiter;

  logic       clk = 1'b0;
  logic       rstN;
  logic       req0, req1, op0, op1;
  logic [3:0] wdata0, wdata1;
  logic       gnt0, gnt1, err0, err1, rvalid0, rvalid1;
  logic [3:0] rdata;
  logic       stk_push, stk_pop;
  logic [3:0] stk_din;
  logic [3:0] stk_dout;
  logic [3:0] count;
`ifdef STACK_ARB_STATS_EN
  logic [7:0] err_cnt, ops_cnt;
`endif

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  stack_arbiter dut (
    .clk      (clk),
    .rstN     (rstN),
    .req0     (req0),
    .req1     (req1),
    .op0      (op0),
    .op1      (op1),
    .wdata0   (wdata0),
    .wdata1   (wdata1),
    .gnt0     (gnt0),
    .gnt1     (gnt1),
    .err0     (err0),
    .err1     (err1),
    .rvalid0  (rvalid0),
    .rvalid1  (rvalid1),
    .rdata    (rdata),
    .stk_push (stk_push),
    .stk_pop  (stk_pop),
    .stk_din  (stk_din),
    .stk_dout (stk_dout),
    .count    (count)
`ifdef STACK_ARB_STATS_EN
    ,
    .err_cnt  (err_cnt),
    .ops_cnt  (ops_cnt)
`endif
  );

  // Behavioural 8-entry LIFO: write on push edge, read data valid after the
  // pop edge, shares rstN with the arbiter.
  logic [3:0] mem [8];
  int         sp;

  always @(posedge clk) begin
    if (!rstN) begin
      sp       <= 0;
      stk_dout <= 4'h0;
    end else if (stk_push && sp < 8) begin
      mem[sp] <= stk_din;
      sp      <= sp + 1;
    end else if (stk_pop && sp > 0) begin
      stk_dout <= mem[sp-1];
      sp       <= sp - 1;
    end
  end

  typedef struct {
    logic       r0, o0;
    logic [3:0] d0;
    logic       r1, o1;
    logic [3:0] d1;
    logic [1:0] e_gnt;
    logic [1:0] e_err;
    logic       e_push, e_pop;
    logic [3:0] e_count;
    logic [1:0] e_rv;
    logic [3:0] e_rdata;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r0, logic o0, logic [3:0] d0,
                              logic r1, logic o1, logic [3:0] d1,
                              logic [1:0] g, logic [1:0] e, logic p, logic q,
                              logic [3:0] c, logic [1:0] rv, logic [3:0] rd);
    vec_t v;
    v.r0 = r0; v.o0 = o0; v.d0 = d0;
    v.r1 = r1; v.o1 = o1; v.d1 = d1;
    v.e_gnt = g; v.e_err = e; v.e_push = p; v.e_pop = q;
    v.e_count = c; v.e_rv = rv; v.e_rdata = rd;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idleInputs();
    req0 = 1'b0; req1 = 1'b0; op0 = 1'b0; op1 = 1'b0;
    wdata0 = 4'h0; wdata1 = 4'h0;
  endtask

  task automatic applyReset();
    idleInputs();
    rstN = 1'b0;
    tick();
    tick();
    rstN = 1'b1;
  endtask

  // One transaction: requests presented for a single edge, then dropped;
  // grant-side results checked after E0, pop results after E2.
  task automatic applyStimulus(input int idx, input vec_t v);
    logic [3:0] exp_din;
    req0 = v.r0; op0 = v.o0; wdata0 = v.d0;
    req1 = v.r1; op1 = v.o1; wdata1 = v.d1;
    tick();
    idleInputs();
    checkOutput($sformatf("v%0d gnt", idx), 32'({gnt1, gnt0}), 32'(v.e_gnt));
    checkOutput($sformatf("v%0d err", idx), 32'({err1, err0}), 32'(v.e_err));
    checkOutput($sformatf("v%0d push", idx), 32'(stk_push), 32'(v.e_push));
    checkOutput($sformatf("v%0d pop", idx), 32'(stk_pop), 32'(v.e_pop));
    checkOutput($sformatf("v%0d count", idx), 32'(count), 32'(v.e_count));
    if (v.e_push) begin
      exp_din = v.e_gnt[1] ? v.d1 : v.d0;
      checkOutput($sformatf("v%0d din", idx), 32'(stk_din), 32'(exp_din));
    end
    tick();
    tick();
    checkOutput($sformatf("v%0d rvalid", idx), 32'({rvalid1, rvalid0}), 32'(v.e_rv));
    checkOutput($sformatf("v%0d rdata", idx), 32'(rdata), 32'(v.e_rdata));
    tick();
  endtask

  initial begin
    idleInputs();
    rstN = 1'b1;

    // Vectors: pointer starts favouring port 0; rejected grants also move it.
    tbl.push_back(mk(1,1,4'h5, 0,0,4'h0, 2'b01,2'b00,1,0,4'd1,2'b00,4'h0));
    tbl.push_back(mk(0,0,4'h0, 1,0,4'h0, 2'b10,2'b00,0,1,4'd0,2'b10,4'h5));
    tbl.push_back(mk(0,0,4'h0, 1,0,4'h0, 2'b10,2'b10,0,0,4'd0,2'b00,4'h5));
    tbl.push_back(mk(1,1,4'h1, 1,1,4'h2, 2'b01,2'b00,1,0,4'd1,2'b00,4'h5));
    tbl.push_back(mk(1,1,4'h1, 1,1,4'h2, 2'b10,2'b00,1,0,4'd2,2'b00,4'h5));
    tbl.push_back(mk(1,1,4'h1, 1,1,4'h2, 2'b01,2'b00,1,0,4'd3,2'b00,4'h5));
    tbl.push_back(mk(1,1,4'h1, 1,1,4'h2, 2'b10,2'b00,1,0,4'd4,2'b00,4'h5));
    tbl.push_back(mk(1,0,4'h0, 0,0,4'h0, 2'b01,2'b00,0,1,4'd3,2'b01,4'h2));
    tbl.push_back(mk(1,0,4'h0, 0,0,4'h0, 2'b01,2'b00,0,1,4'd2,2'b01,4'h1));
    tbl.push_back(mk(1,0,4'h0, 0,0,4'h0, 2'b01,2'b00,0,1,4'd1,2'b01,4'h2));
    tbl.push_back(mk(1,0,4'h0, 0,0,4'h0, 2'b01,2'b00,0,1,4'd0,2'b01,4'h1));
    tbl.push_back(mk(1,0,4'h0, 0,0,4'h0, 2'b01,2'b01,0,0,4'd0,2'b00,4'h1));
    for (int i = 1; i <= 8; i++)
      tbl.push_back(mk(1,1,4'(i), 0,0,4'h0, 2'b01,2'b00,1,0,4'(i),2'b00,4'h1));
    tbl.push_back(mk(1,1,4'hF, 0,0,4'h0, 2'b01,2'b01,0,0,4'd8,2'b00,4'h1));
    tbl.push_back(mk(0,0,4'h0, 1,1,4'hE, 2'b10,2'b10,0,0,4'd8,2'b00,4'h1));

    // Reset then idle
    applyReset();
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput($sformatf("idle%0d pulses", i),
                  32'({gnt0, gnt1, err0, err1, rvalid0, rvalid1, stk_push, stk_pop}), 32'h0);
      checkOutput($sformatf("idle%0d count", i), 32'(count), 32'h0);
    end
    checkOutput("reset rdata", 32'(rdata), 32'h0);
    checkOutput("reset din", 32'(stk_din), 32'h0);

    for (int i = 0; i < tbl.size(); i++)
      applyStimulus(i, tbl[i]);

    // Reset mid-pop: rstN low during POP_WAIT aborts with no rvalid
    req0 = 1'b1; op0 = 1'b0;
    tick();
    idleInputs();
    checkOutput("midpop gnt0", 32'(gnt0), 32'h1);
    checkOutput("midpop count7", 32'(count), 32'd7);
    tick();
    rstN = 1'b0;
    tick();
    checkOutput("midpop rvalid", 32'({rvalid1, rvalid0}), 32'h0);
    rstN = 1'b1;
    tick();
    checkOutput("midpop count0", 32'(count), 32'h0);
    checkOutput("midpop pulses",
                32'({gnt0, gnt1, err0, err1, rvalid0, rvalid1, stk_push, stk_pop}), 32'h0);

    // Held push request: grants at E0 and E2
    req0 = 1'b1; op0 = 1'b1; wdata0 = 4'hA;
    tick();
    checkOutput("held push g1", 32'(gnt0), 32'h1);
    tick();
    checkOutput("held push gap", 32'(gnt0), 32'h0);
    tick();
    checkOutput("held push g2", 32'(gnt0), 32'h1);
    checkOutput("held push count", 32'(count), 32'd2);
    idleInputs();
    tick();
    tick();

    // Held pop request: rvalid at E2, next grant at E3
    req1 = 1'b1; op1 = 1'b0;
    tick();
    checkOutput("held pop g1", 32'(gnt1), 32'h1);
    checkOutput("held pop count", 32'(count), 32'd1);
    tick();
    checkOutput("held pop gap", 32'(gnt1), 32'h0);
    tick();
    checkOutput("held pop rvalid", 32'({rvalid1, rvalid0}), 32'h2);
    checkOutput("held pop rdata", 32'(rdata), 32'hA);
    checkOutput("held pop gap2", 32'(gnt1), 32'h0);
    tick();
    checkOutput("held pop g2", 32'(gnt1), 32'h1);
    checkOutput("held pop count0", 32'(count), 32'd0);
    idleInputs();
    tick();
    tick();
    tick();

`ifdef STACK_ARB_STATS_EN
    applyReset();
    checkOutput("stats reset err", 32'(err_cnt), 32'h0);
    applyStimulus(100, mk(1,0,4'h0, 0,0,4'h0, 2'b01,2'b01,0,0,4'd0,2'b00,4'h0));
    applyStimulus(101, mk(0,0,4'h0, 1,0,4'h0, 2'b10,2'b10,0,0,4'd0,2'b00,4'h0));
    applyStimulus(102, mk(1,1,4'h3, 0,0,4'h0, 2'b01,2'b00,1,0,4'd1,2'b00,4'h0));
    applyStimulus(103, mk(0,0,4'h0, 1,1,4'h4, 2'b10,2'b00,1,0,4'd2,2'b00,4'h0));
    applyStimulus(104, mk(1,0,4'h0, 0,0,4'h0, 2'b01,2'b00,0,1,4'd1,2'b01,4'h4));
    checkOutput("stats err_cnt", 32'(err_cnt), 32'd2);
    checkOutput("stats ops_cnt", 32'(ops_cnt), 32'd3);
    applyReset();
    req0 = 1'b1; op0 = 1'b0;
    for (int i = 0; i < 300; i++) tick();
    idleInputs();
    tick();
    checkOutput("stats err_cnt sat", 32'(err_cnt), 32'd255);
    checkOutput("stats ops_cnt zero", 32'(ops_cnt), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
